// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants, address-width helper and address type for the scoreboarded register file.
// The optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int CNTW_DEF  = 2;

   // A one-entry file still needs a one-bit address bus.
   function automatic int addrWidth(input int nRegs);
      return (nRegs <= 1) ? 1 : $clog2(nRegs);
   endfunction

   localparam int AW_DEF = addrWidth(NREGS_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_read_port.sv
// One combinational read port: register mux, x0 zeroing, pending-write busy flag.
// With REGFILE_BYPASS_EN defined, a same-cycle write-back is forwarded and retires its hazard.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int CNTW  = CNTW_DEF,
   parameter int AW    = addrWidth(NREGS)
) (
   input  logic [AW-1:0]         addr_i,
   input  logic [NREGS*XLEN-1:0] regFlat_i,
   input  logic [NREGS*CNTW-1:0] cntFlat_i,
   input  logic                  wrEn_i,
   input  logic [AW-1:0]         wrAddr_i,
   input  logic [XLEN-1:0]       wrData_i,
   output logic [XLEN-1:0]       data_o,
   output logic                  busy_o
);

   logic [XLEN-1:0] rawData;
   logic [CNTW-1:0] rawCnt;
   logic            isZeroReg;

   assign rawData   = regFlat_i[addr_i*XLEN +: XLEN];
   assign rawCnt    = cntFlat_i[addr_i*CNTW +: CNTW];
   assign isZeroReg = (addr_i == '0);

`ifdef REGFILE_BYPASS_EN
   logic bypassHit;

   assign bypassHit = wrEn_i && (wrAddr_i == addr_i) && !isZeroReg;

   // A hitting write-back retires one pending write, so only a count above one stays busy.
   always_comb begin
      data_o = '0;
      busy_o = 1'b0;
      if (bypassHit) begin
         data_o = wrData_i;
         busy_o = (rawCnt > CNTW'(1));
      end else if (!isZeroReg) begin
         data_o = rawData;
         busy_o = (rawCnt != '0);
      end
   end
`else
   logic unusedBypass;

   assign unusedBypass = ^{wrEn_i, wrAddr_i, wrData_i};

   // Without bypass the port shows only pre-edge state.
   always_comb begin
      data_o = '0;
      busy_o = 1'b0;
      if (!isZeroReg) begin
         data_o = rawData;
         busy_o = (rawCnt != '0);
      end
   end
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NRD read ports, one write port and per-register saturating pending-write counters.
// Define REGFILE_BYPASS_EN to forward same-cycle write-backs to the read ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF,
   parameter int CNTW  = CNTW_DEF,
   localparam int AW   = addrWidth(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic                alloc_ready,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                flush
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   logic [XLEN-1:0]       regData_q [NREGS];
   logic [CNTW-1:0]       pendCnt_q [NREGS];
   logic [CNTW-1:0]       pendCnt_d [NREGS];
   logic [NREGS*XLEN-1:0] regFlat;
   logic [NREGS*CNTW-1:0] cntFlat;
   logic                  allocAccept;
   logic                  wrValid;

   // Ready depends only on the target and current count, keeping issue free of loops.
   assign alloc_ready = (alloc_addr == '0) || (pendCnt_q[alloc_addr] != CNT_MAX);
   assign allocAccept = alloc_en && alloc_ready && (alloc_addr != '0);
   assign wrValid     = wr_en && (wr_addr != '0);

   // An allocation and write-back to the same register cancel out; flush clears everything.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         pendCnt_d[r] = pendCnt_q[r];
         unique case ({allocAccept && (alloc_addr == AW'(r)), wrValid && (wr_addr == AW'(r))})
            2'b10:   pendCnt_d[r] = pendCnt_q[r] + 1'b1;
            2'b01:   pendCnt_d[r] = (pendCnt_q[r] == '0) ? pendCnt_q[r] : pendCnt_q[r] - 1'b1;
            default: pendCnt_d[r] = pendCnt_q[r];
         endcase
         if (flush || (r == 0)) begin
            pendCnt_d[r] = '0;
         end
      end
   end

   // Reset clears both data and counters and overrides every other request.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regData_q[r] <= '0;
            pendCnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            pendCnt_q[r] <= pendCnt_d[r];
         end
         if (wrValid) begin
            regData_q[wr_addr] <= wr_data;
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : gFlat
      assign regFlat[g*XLEN +: XLEN] = regData_q[g];
      assign cntFlat[g*CNTW +: CNTW] = pendCnt_q[g];
   end

   for (genvar p = 0; p < NRD; p++) begin : gReadPort
      regfile_read_port #(
         .XLEN  (XLEN),
         .NREGS (NREGS),
         .CNTW  (CNTW),
         .AW    (AW)
      ) uReadPort (
         .addr_i    (rd_addr[p*AW +: AW]),
         .regFlat_i (regFlat),
         .cntFlat_i (cntFlat),
         .wrEn_i    (wr_en),
         .wrAddr_i  (wr_addr),
         .wrData_i  (wr_data),
         .data_o    (rd_data[p*XLEN +: XLEN]),
         .busy_o    (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: array-and-integer model plus directed literal checks.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRD = 2;
   localparam int AW = 5;
   localparam int CMAX = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              alloc_en;
   reg_addr_t         alloc_addr;
   logic              alloc_ready;
   logic              wr_en;
   reg_addr_t         wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic              flush;

   int compared = 0;
   int mismatched = 0;

   int unsigned mRf [NREGS];
   int          mCnt [NREGS];
   bit          modelValid = 1'b0;

   regfile_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .alloc_en    (alloc_en),
      .alloc_addr  (alloc_addr),
      .alloc_ready (alloc_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   task automatic compareOne(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural effect of one clock edge, using the inputs held during the cycle.
   task automatic modelStep();
      bit accepted;
      int n;
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            mRf[r] = 0;
            mCnt[r] = 0;
         end
         modelValid = 1'b1;
      end else begin
         accepted = alloc_en && (alloc_addr == 0 || mCnt[alloc_addr] != CMAX);
         if (wr_en && wr_addr != 0) mRf[wr_addr] = wr_data;
         for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
               mCnt[r] = 0;
            end else begin
               n = mCnt[r] + ((accepted && alloc_addr == r) ? 1 : 0) - ((wr_en && wr_addr == r) ? 1 : 0);
               mCnt[r] = (n < 0) ? 0 : n;
            end
         end
      end
   endtask

   task automatic checkOutput();
      int a;
      int unsigned expData;
      int busyN;
      bit expReady;
      for (int p = 0; p < NRD; p++) begin
         a = int'(rd_addr[p*AW +: AW]);
         expData = (a == 0) ? 0 : mRf[a];
         busyN = (a == 0) ? 0 : mCnt[a];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && wr_addr == a && a != 0) begin
            expData = wr_data;
            busyN = busyN - 1;
         end
`endif
         compareOne($sformatf("model_rd_data[%0d] x%0d", p, a), rd_data[p*XLEN +: XLEN], expData);
         compareOne($sformatf("model_rd_busy[%0d] x%0d", p, a), 32'(rd_busy[p]), 32'(busyN > 0));
      end
      expReady = (alloc_addr == 0) || (mCnt[alloc_addr] != CMAX);
      compareOne($sformatf("model_alloc_ready x%0d", alloc_addr), 32'(alloc_ready), 32'(expReady));
   endtask

   always @(negedge clk) begin
      if (modelValid) checkOutput();
   end

   task automatic applyStimulus(input int ra0, input int ra1, input bit aEn, input int aAddr,
                                input bit wEn, input int wAddr, input logic [31:0] wData,
                                input bit fl, input bit rst);
      @(posedge clk);
      modelStep();
      #1;
      rd_addr    = {AW'(ra1), AW'(ra0)};
      alloc_en   = aEn;
      alloc_addr = AW'(aAddr);
      wr_en      = wEn;
      wr_addr    = AW'(wAddr);
      wr_data    = wData;
      flush      = fl;
      reset      = rst;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rd_addr = '0;
      alloc_en = 1'b0;
      alloc_addr = '0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      flush = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int a = 0; a < NREGS; a++) begin
         applyStimulus(a, NREGS - 1 - a, 0, a, 0, 0, 0, 0, 0);
         settle();
         compareOne("reset_rd_data", rd_data, 64'h0);
         compareOne("reset_rd_busy", 32'(rd_busy), 32'h0);
         compareOne("reset_alloc_ready", 32'(alloc_ready), 32'h1);
      end

      applyStimulus(3, 0, 1, 3, 0, 0, 0, 0, 0);
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x3_busy_after_alloc", 32'(rd_busy[0]), 32'h1);
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(3, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0);
      settle();
`ifdef REGFILE_BYPASS_EN
      compareOne("x3_write_cycle_data", rd_data[31:0], 32'hDEADBEEF);
      compareOne("x3_write_cycle_busy", 32'(rd_busy[0]), 32'h0);
`else
      compareOne("x3_write_cycle_data", rd_data[31:0], 32'h0);
      compareOne("x3_write_cycle_busy", 32'(rd_busy[0]), 32'h1);
`endif
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x3_after_write_data", rd_data[31:0], 32'hDEADBEEF);
      compareOne("x3_after_write_busy", 32'(rd_busy[0]), 32'h0);

      for (int k = 0; k < 3; k++) applyStimulus(7, 0, 1, 7, 0, 0, 0, 0, 0);
      applyStimulus(7, 0, 0, 7, 0, 0, 0, 0, 0);
      settle();
      compareOne("x7_full_ready", 32'(alloc_ready), 32'h0);
      compareOne("x7_full_busy", 32'(rd_busy[0]), 32'h1);
      applyStimulus(7, 0, 1, 7, 0, 0, 0, 0, 0);
      applyStimulus(7, 0, 0, 7, 1, 7, 32'h70, 0, 0);
      settle();
      compareOne("x7_still_full_ready", 32'(alloc_ready), 32'h0);
      applyStimulus(7, 0, 0, 7, 0, 0, 0, 0, 0);
      settle();
      compareOne("x7_after_write_ready", 32'(alloc_ready), 32'h1);
      compareOne("x7_after_write_busy", 32'(rd_busy[0]), 32'h1);
      applyStimulus(7, 0, 0, 7, 1, 7, 32'h71, 0, 0);
      applyStimulus(7, 0, 0, 7, 1, 7, 32'h72, 0, 0);
      applyStimulus(7, 0, 0, 7, 0, 0, 0, 0, 0);
      settle();
      compareOne("x7_drained_busy", 32'(rd_busy[0]), 32'h0);
      compareOne("x7_drained_data", rd_data[31:0], 32'h72);

      applyStimulus(9, 0, 1, 9, 0, 0, 0, 0, 0);
      applyStimulus(9, 0, 1, 9, 1, 9, 32'hA5A5, 0, 0);
      applyStimulus(9, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x9_same_cycle_data", rd_data[31:0], 32'hA5A5);
      compareOne("x9_same_cycle_busy", 32'(rd_busy[0]), 32'h1);
      applyStimulus(9, 0, 0, 0, 1, 9, 32'hA5A6, 0, 0);

      applyStimulus(0, 0, 1, 0, 1, 0, 32'h1234, 0, 0);
      settle();
      compareOne("x0_alloc_ready", 32'(alloc_ready), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x0_rd_data", rd_data, 64'h0);
      compareOne("x0_rd_busy", 32'(rd_busy), 32'h0);
      compareOne("x0_ready_after", 32'(alloc_ready), 32'h1);

      for (int k = 0; k < 3; k++) applyStimulus(4, 0, 1, 4, 0, 0, 0, 0, 0);
      applyStimulus(4, 0, 0, 4, 0, 0, 0, 0, 0);
      settle();
      compareOne("x4_full_ready", 32'(alloc_ready), 32'h0);
      applyStimulus(4, 0, 1, 4, 1, 4, 32'h55, 1, 0);
      applyStimulus(4, 0, 0, 4, 0, 0, 0, 0, 0);
      settle();
      compareOne("x4_flush_data", rd_data[31:0], 32'h55);
      compareOne("x4_flush_busy", 32'(rd_busy[0]), 32'h0);
      compareOne("x4_flush_ready", 32'(alloc_ready), 32'h1);
      applyStimulus(4, 0, 0, 0, 1, 4, 32'h66, 0, 0);
      applyStimulus(4, 0, 1, 4, 0, 0, 0, 0, 0);
      settle();
      compareOne("x4_no_underflow_busy", 32'(rd_busy[0]), 32'h0);
      compareOne("x4_zero_cnt_write_data", rd_data[31:0], 32'h66);
      applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x4_single_alloc_busy", 32'(rd_busy[0]), 32'h1);
      applyStimulus(4, 0, 0, 0, 1, 4, 32'h67, 0, 0);
      applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x4_final_busy", 32'(rd_busy[0]), 32'h0);

      applyStimulus(5, 0, 0, 0, 1, 5, 32'h77, 0, 0);
      applyStimulus(5, 0, 1, 5, 0, 0, 0, 0, 0);
      applyStimulus(5, 0, 1, 5, 0, 0, 0, 0, 0);
      applyStimulus(5, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x5_pre_reset_busy", 32'(rd_busy[0]), 32'h1);
      compareOne("x5_pre_reset_data", rd_data[31:0], 32'h77);
      applyStimulus(5, 0, 1, 5, 1, 5, 32'h99, 1, 1);
      applyStimulus(5, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      compareOne("x5_post_reset_busy", 32'(rd_busy[0]), 32'h0);
      compareOne("x5_post_reset_data", rd_data[31:0], 32'h0);
      applyStimulus(5, 0, 0, 0, 1, 5, 32'h88, 0, 0);
      applyStimulus(5, 0, 0, 5, 0, 0, 0, 0, 0);
      settle();
      compareOne("x5_late_write_data", rd_data[31:0], 32'h88);
      compareOne("x5_late_write_busy", 32'(rd_busy[0]), 32'h0);

      for (int k = 0; k < 400; k++) begin
         applyStimulus($urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
                       $urandom_range(0, 31) == 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
